// File: rtl/aes_sub_multi.sv
// AES byte substitution over two source registers using SBOXES parallel S-boxes
// (1, 2 or 4). AES_SUB_MULTI_OUTREG_EN registers the result and ready flag.
module aes_sub_multi #(
    parameter int SBOXES = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] rd
);

    localparam int unsigned NSB   = SBOXES;
    localparam int unsigned STEPS = 4 / NSB;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 = product of a^2, a^4 .. a^128; maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] p;
        s = gmul(a, a);
        p = s;
        for (int unsigned i = 2; i < 8; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    logic [CW-1:0] step;
    logic          last;
    logic          hold;
    logic          fire;
    logic          adv;
    logic [1:0]    base;
    logic [7:0]    src    [4];
    logic [7:0]    r      [4];
    logic [7:0]    res    [4];
    logic [7:0]    sb_out [NSB];
    logic [31:0]   word;
    logic [31:0]   word_rot;
    logic          unused_bits;

    assign src[0] = rs1[7:0];
    assign src[1] = rs2[15:8];
    assign src[2] = rs1[23:16];
    assign src[3] = rs2[31:24];
    assign unused_bits = ^{rs1[15:8], rs1[31:24], rs2[7:0], rs2[23:16]};

    assign last = (step == CW'(STEPS - 1));
    assign base = 2'(32'(step) * NSB);
    assign adv  = valid && !last && !hold;
    assign fire = valid && last && !hold && !g_resetn;

    for (genvar j = 0; j < SBOXES; j++) begin : g_sbox
        logic [7:0] sb_in;
        assign sb_in     = src[base + 2'(j)];
        assign sb_out[j] = enc ? sbox_fwd(sb_in) : sbox_inv(sb_in);
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) res[i] = r[i];
        for (int unsigned j = 0; j < NSB; j++) res[base + 2'(j)] = sb_out[j];
    end

    assign word     = {res[3], res[2], res[1], res[0]};
    assign word_rot = rot ? {word[23:0], word[31:24]} : word;

    always_ff @(posedge g_clk) begin
        if (g_resetn) begin
            step <= '0;
            for (int unsigned i = 0; i < 4; i++) r[i] <= '0;
        end else if (adv) begin
            step <= step + CW'(1);
            for (int unsigned j = 0; j < NSB; j++) r[base + 2'(j)] <= sb_out[j];
        end else begin
            step <= '0;
        end
    end

`ifdef AES_SUB_MULTI_OUTREG_EN
    logic        ready_q;
    logic [31:0] rd_q;

    // the registered-ready cycle holds the counter at 0 and suppresses a re-fire
    assign hold = ready_q;

    always_ff @(posedge g_clk) begin
        if (g_resetn) begin
            ready_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            ready_q <= fire;
            rd_q    <= fire ? word_rot : '0;
        end
    end

    assign ready = ready_q && !g_resetn;
    assign rd    = ready ? rd_q : '0;
`else
    assign hold  = 1'b0;
    assign ready = fire;
    assign rd    = fire ? word_rot : '0;
`endif

endmodule

// File: tb/tb_aes_sub_multi.sv
// Directed bench for aes_sub_multi: SBOXES=1, 2 and 4 instances share stimulus.
module tb_aes_sub_multi;

`ifdef AES_SUB_MULTI_OUTREG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        valid;
    logic        enc;
    logic        rot;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rdy1, rdy2, rdy4;
    logic [31:0] rd1, rd2, rd4;

    int n_tests = 0;
    int n_fail  = 0;

    aes_sub_multi #(.SBOXES(1)) u_sb1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .rs1(rs1), .rs2(rs2),
        .enc(enc), .rot(rot), .ready(rdy1), .rd(rd1)
    );
    aes_sub_multi #(.SBOXES(2)) u_sb2 (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .rs1(rs1), .rs2(rs2),
        .enc(enc), .rot(rot), .ready(rdy2), .rd(rd2)
    );
    aes_sub_multi #(.SBOXES(4)) u_sb4 (
        .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid), .rs1(rs1), .rs2(rs2),
        .enc(enc), .rot(rot), .ready(rdy4), .rd(rd4)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic get_outs(input int d, output logic r_o, output logic [31:0] d_o);
        case (d)
            0:       begin r_o = rdy1; d_o = rd1; end
            1:       begin r_o = rdy2; d_o = rd2; end
            default: begin r_o = rdy4; d_o = rd4; end
        endcase
    endtask

    // Cycle k of an operation (valid held for cycles 1..ncyc); ready recurs every
    // STEPS(+1 with the output register) cycles while valid stays high.
    task automatic check_outs(input string name, input int k, input bit active,
                              input logic [31:0] exp);
        for (int d = 0; d < 3; d++) begin
            int          p;
            bit          er;
            logic        r_o;
            logic [31:0] d_o;
            p  = (4 >> d) + EXTRA;
            er = ((k % p) == 0) && (active || EXTRA == 1);
            get_outs(d, r_o, d_o);
            check($sformatf("%s k%0d sb%0d ready", name, k, 1 << d), {31'b0, r_o}, {31'b0, er});
            check($sformatf("%s k%0d sb%0d rd", name, k, 1 << d), d_o, er ? exp : 32'h0);
        end
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 3; d++) begin
            logic        r_o;
            logic [31:0] d_o;
            get_outs(d, r_o, d_o);
            check($sformatf("%s sb%0d ready", name, 1 << d), {31'b0, r_o}, 32'h0);
            check($sformatf("%s sb%0d rd", name, 1 << d), d_o, 32'h0);
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic e, input logic ro, input logic [31:0] exp,
                          input int ncyc);
        rs1   = a;
        rs2   = b;
        enc   = e;
        rot   = ro;
        valid = 1'b1;
        for (int k = 1; k <= ncyc + 1; k++) begin
            if (k == ncyc + 1) valid = 1'b0;
            @(negedge g_clk);
            check_outs(name, k, k <= ncyc, exp);
            @(posedge g_clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        g_resetn = 1'b1;
        valid    = 1'b1;
        rs1      = 32'h00530001;
        rs2      = 32'hFF001000;
        enc      = 1'b1;
        rot      = 1'b0;
        repeat (2) begin
            @(negedge g_clk);
            check_zero("reset");
            @(posedge g_clk);
            #1;
        end
        g_resetn = 1'b0;
        valid    = 1'b0;
        @(negedge g_clk);
        check_zero("idle_after_reset");
        @(posedge g_clk);
        #1;

        run_op("fwd",     32'h00530001, 32'hFF001000, 1'b1, 1'b0, 32'h16EDCA7C, 8);
        run_op("fwd_rot", 32'h00530001, 32'hFF001000, 1'b1, 1'b1, 32'hEDCA7C16, 8);
        run_op("inv",     32'h00000063, 32'h7C007C00, 1'b0, 1'b0, 32'h01520100, 8);
        run_op("inv_rot", 32'h00000063, 32'h7C007C00, 1'b0, 1'b1, 32'h52010001, 4);
        run_op("fwd_00",  32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h63636363, 4);
        run_op("fwd_ff",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h16161616, 4);
        run_op("inv_16",  32'h16161616, 32'h16161616, 1'b0, 1'b0, 32'hFFFFFFFF, 4);

        run_op("abort",       32'h00530001, 32'hFF001000, 1'b1, 1'b0, 32'h16EDCA7C, 2);
        run_op("after_abort", 32'h00000063, 32'h7C007C00, 1'b0, 1'b0, 32'h01520100, 4);

        rs1   = 32'h00530001;
        rs2   = 32'hFF001000;
        enc   = 1'b1;
        rot   = 1'b0;
        valid = 1'b1;
        @(negedge g_clk);
        check_outs("pre_rst", 1, 1'b1, 32'h16EDCA7C);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        check_zero("mid_op_reset");
        @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        run_op("post_rst", 32'h00000063, 32'h7C007C00, 1'b0, 1'b0, 32'h01520100, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_sub_multi.md
AES_SUB_MULTI -- requirements
Module: aes_sub_multi

Interface
REQ-001 SHALL have parameter SBOXES, default 1, number of parallel S-box instances; legal values 1, 2, 4.
REQ-002 SHALL have port g_clk input 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port g_resetn input 1: reset. One clock; reset is synchronous and active-high.
REQ-004 SHALL have port valid input 1: operation request; held high with stable operands until ready.
REQ-005 SHALL have port rs1 input 32: source register 1, supplies bytes 0 and 2.
REQ-006 SHALL have port rs2 input 32: source register 2, supplies bytes 1 and 3.
REQ-007 SHALL have port enc input 1: 1 = forward S-box, 0 = inverse S-box.
REQ-008 SHALL have port rot input 1: 1 = rotate result left by 8 bits.
REQ-009 SHALL have port ready output 1: result valid this cycle.
REQ-010 SHALL have port rd output 32: result word.

Function
REQ-011 SHALL define STEPS = 4/SBOXES and a step counter of width max(1,log2(STEPS)) covering 0..STEPS-1.
REQ-012 SHALL define source byte i (0..3) as rs1[8i+7:8i] for even i and rs2[8i+7:8i] for odd i.
REQ-013 SHALL, in step s, feed source bytes s*SBOXES .. s*SBOXES+SBOXES-1 into S-boxes 0..SBOXES-1, one byte per S-box.
REQ-014 SHALL store each S-box output of a non-final step in result byte register r[i] when valid is high.
REQ-015 SHALL advance the counter by one per cycle while valid is high and the step is not final.
REQ-016 SHALL assert ready combinationally when valid is high and the counter equals STEPS-1; latency is STEPS cycles from valid rising.
REQ-017 SHALL, when ready, form R = {b3,b2,b1,b0}: bytes of the final step taken directly from S-box outputs, all others from r[i].
REQ-018 SHALL drive rd = R when rot=0 and rd = {b2,b1,b0,b3} when rot=1, while ready is high.
REQ-019 SHALL drive rd = 32'h0 whenever ready is low.
REQ-020 SHALL return the counter to 0 on the cycle after ready; if valid stays high, a new operation starts there.
REQ-021 SHALL abort on valid low mid-operation: counter returns to 0 next cycle, r[i] unchanged, no ready.
REQ-022 SHALL, for SBOXES=4, be purely combinational in data path: ready = valid, counter constant 0, no r[i] writes.
REQ-023 SHALL apply enc and rot as sampled in each cycle; both are required stable while valid is high.

Reset
REQ-024 SHALL, when g_resetn is high at a rising edge, clear the counter to 0 and all r[i] to 8'h00, overriding valid.
REQ-025 SHALL hold ready = 0 and rd = 0 during any reset cycle and in the first cycle after reset unless STEPS=1 and valid=1.
REQ-026 SHALL, on reset mid-operation, discard partial results; a subsequent valid restarts at step 0.

Configuration
REQ-027 SHALL support macro AES_SUB_MULTI_OUTREG_EN.
REQ-028 SHALL, without AES_SUB_MULTI_OUTREG_EN, behave exactly as REQ-011..REQ-026.
REQ-029 SHALL, with AES_SUB_MULTI_OUTREG_EN, register the final-step result (after rotation) and a ready flag; ready and rd appear one cycle later (latency STEPS+1).
REQ-030 SHALL, with AES_SUB_MULTI_OUTREG_EN, assert ready for exactly one cycle, hold the counter at 0 during that cycle, and clear both registers on reset.

Verification
REQ-031 SBOXES=1, enc=1, rot=0, rs1=32'h00530001, rs2=32'hFF001000, valid held -> ready high on 4th valid cycle only, rd=32'h16EDCA7C.
REQ-032 Same stimulus, rot=1 -> rd=32'hEDCA7C16; SBOXES=2 -> same rd, ready on 2nd cycle; SBOXES=4 -> ready on 1st cycle.
REQ-033 SBOXES=1, enc=0, rot=0, rs1=32'h00000063, rs2=32'h7C007C00 -> rd=32'h01520100 on 4th cycle.
REQ-034 SBOXES=1, valid dropped after 2 cycles, then reasserted with new operands -> no ready at abort, result after 4 further cycles matches new operands only.
REQ-035 SBOXES=2, g_resetn pulsed after 1st step -> ready low, rd=0; next valid completes in 2 cycles with correct result.
REQ-036 AES_SUB_MULTI_OUTREG_EN, SBOXES=1, REQ-031 stimulus -> ready one cycle on 5th cycle, rd=32'h16EDCA7C, rd=0 otherwise.
